// File: rtl/morse_pkg.sv
// Shared Morse timing definitions: key FSM state type and default tick thresholds
// used by the key timer, game control and scoring blocks.
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS,
      GAP
   } key_state_t;

   localparam int unsigned DASH_TICKS_DEF       = 3;
   localparam int unsigned LETTER_GAP_TICKS_DEF = 3;
   localparam int unsigned WORD_GAP_TICKS_DEF   = 7;

endpackage

// File: rtl/morse_key_timer_if.sv
// Event bundle from the key timer to game control: symbol, gap pulses and busy.
interface morse_key_timer_if;

   logic sym_valid;
   logic sym_dash;
   logic letter_end;
   logic word_end;
   logic busy;

   modport master (
      output sym_valid,
      output sym_dash,
      output letter_end,
      output word_end,
      output busy
   );

   modport slave (
      input sym_valid,
      input sym_dash,
      input letter_end,
      input word_end,
      input busy
   );

endinterface

// File: rtl/morse_tick_cnt.sv
// Saturating duration counter advanced by the 100 ms tick; clr beats tick.
module morse_tick_cnt #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             tick,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (tick && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/morse_key_timer.sv
// Classifies debounced key activity into dot/dash symbols and letter/word gaps,
// timed by the shared 100 ms tick; all event outputs are registered pulses.
module morse_key_timer
   import morse_pkg::*;
#(
   parameter int unsigned DASH_TICKS       = DASH_TICKS_DEF,
   parameter int unsigned LETTER_GAP_TICKS = LETTER_GAP_TICKS_DEF,
   parameter int unsigned WORD_GAP_TICKS   = WORD_GAP_TICKS_DEF,
   parameter int unsigned CNT_W            = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               HundredmsTimeOut,
   input  logic               enable,
   input  logic               key,
   morse_key_timer_if.master  ev
);

   localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_TICKS);
   localparam logic [CNT_W-1:0] LETTER_C = CNT_W'(LETTER_GAP_TICKS);
   localparam logic [CNT_W-1:0] WORD_C   = CNT_W'(WORD_GAP_TICKS);

   key_state_t       state, state_n;
   logic             key_q;
   logic             rise, fall;
   logic             clr, tick_en;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic             sv_n, dash_n, le_n, we_n;

   // key_q tracks key even while disabled so a held key never looks like a fresh press
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) key_q <= 1'b0;
      else      key_q <= key;
   end

   assign rise    = key & ~key_q;
   assign fall    = ~key & key_q;
   assign tick_en = HundredmsTimeOut & enable & (state != IDLE);
   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   morse_tick_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .tick  (tick_en),
      .count (cnt)
   );

   always_comb begin
      state_n = state;
      clr     = 1'b0;
      sv_n    = 1'b0;
      dash_n  = 1'b0;
      le_n    = 1'b0;
      we_n    = 1'b0;
      if (!enable) begin
         state_n = IDLE;
         clr     = 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (rise) begin
                  state_n = PRESS;
                  clr     = 1'b1;
               end
            end
            PRESS: begin
               if (fall) begin
                  sv_n    = 1'b1;
                  dash_n  = (cnt >= DASH_C);
                  state_n = GAP;
                  clr     = 1'b1;
               end
            end
            GAP: begin
               if (rise) begin
                  state_n = PRESS;
                  clr     = 1'b1;
               end else if (HundredmsTimeOut) begin
                  // thresholds are judged on the value this tick is about to store
                  le_n = (cnt_inc == LETTER_C);
                  if (cnt_inc == WORD_C) begin
                     we_n    = 1'b1;
                     state_n = IDLE;
                     clr     = 1'b1;
                  end
               end
            end
            default: begin
               state_n = IDLE;
               clr     = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         ev.sym_valid  <= 1'b0;
         ev.sym_dash   <= 1'b0;
         ev.letter_end <= 1'b0;
         ev.word_end   <= 1'b0;
         ev.busy       <= 1'b0;
      end else begin
         state         <= state_n;
         ev.sym_valid  <= sv_n;
         ev.sym_dash   <= dash_n;
         ev.letter_end <= le_n;
         ev.word_end   <= we_n;
         ev.busy       <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_morse_key_timer.sv
// Directed and randomized bench for morse_key_timer against a tick-counting reference model.
module tb_morse_key_timer;
   import morse_pkg::*;

   localparam int unsigned DT = 3;
   localparam int unsigned LG = 3;
   localparam int unsigned WG = 7;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic HundredmsTimeOut = 1'b0;
   logic enable = 1'b0;
   logic key = 1'b0;

   int checks = 0;
   int errors = 0;

   morse_key_timer_if mif ();

   morse_key_timer #(
      .DASH_TICKS       (DT),
      .LETTER_GAP_TICKS (LG),
      .WORD_GAP_TICKS   (WG),
      .CNT_W            (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .HundredmsTimeOut (HundredmsTimeOut),
      .enable           (enable),
      .key              (key),
      .ev               (mif)
   );

   always #5 clk = ~clk;

   // Reference: unbounded press/gap tick tallies, key history, predicted pulses.
   bit m_pressing, m_gapping, m_kq;
   int m_press_ticks, m_gap_ticks;
   bit e_sv, e_dash, e_le, e_we, e_busy;

   task automatic model_reset();
      m_pressing = 0; m_gapping = 0; m_kq = 0;
      m_press_ticks = 0; m_gap_ticks = 0;
      e_sv = 0; e_dash = 0; e_le = 0; e_we = 0; e_busy = 0;
   endtask

   task automatic model_edge(input bit k, input bit t, input bit en);
      bit r, f;
      r = k && !m_kq;
      f = !k && m_kq;
      e_sv = 0; e_dash = 0; e_le = 0; e_we = 0;
      if (!en) begin
         m_pressing = 0;
         m_gapping  = 0;
      end else if (m_pressing) begin
         if (f) begin
            e_sv = 1;
            e_dash = (m_press_ticks >= int'(DT));
            m_pressing = 0;
            m_gapping = 1;
            m_gap_ticks = 0;
         end else if (t) begin
            m_press_ticks++;
         end
      end else if (m_gapping) begin
         if (r) begin
            m_gapping = 0;
            m_pressing = 1;
            m_press_ticks = 0;
         end else if (t) begin
            m_gap_ticks++;
            if (m_gap_ticks == int'(LG)) e_le = 1;
            if (m_gap_ticks == int'(WG)) begin
               e_we = 1;
               m_gapping = 0;
            end
         end
      end else if (r) begin
         m_pressing = 1;
         m_press_ticks = 0;
      end
      m_kq = k;
      e_busy = m_pressing || m_gapping;
   endtask

   task automatic check_outputs(input string tag);
      checks++;
      assert (mif.sym_valid === e_sv) else begin
         errors++;
         $error("FAIL %s sym_valid got %0b expected %0b", tag, mif.sym_valid, e_sv);
      end
      checks++;
      assert (mif.sym_dash === e_dash) else begin
         errors++;
         $error("FAIL %s sym_dash got %0b expected %0b", tag, mif.sym_dash, e_dash);
      end
      checks++;
      assert (mif.letter_end === e_le) else begin
         errors++;
         $error("FAIL %s letter_end got %0b expected %0b", tag, mif.letter_end, e_le);
      end
      checks++;
      assert (mif.word_end === e_we) else begin
         errors++;
         $error("FAIL %s word_end got %0b expected %0b", tag, mif.word_end, e_we);
      end
      checks++;
      assert (mif.busy === e_busy) else begin
         errors++;
         $error("FAIL %s busy got %0b expected %0b", tag, mif.busy, e_busy);
      end
   endtask

   // One clock: drive at negedge, model the sampling edge, compare just after it.
   task automatic step(input bit k, input bit t, input string tag);
      @(negedge clk);
      key = k;
      HundredmsTimeOut = t;
      @(posedge clk);
      if (rst) model_edge(k, t, enable);
      else     model_reset();
      #1;
      check_outputs(tag);
   endtask

   task automatic hold(input bit k, input int n_ticks, input string tag);
      for (int i = 0; i < n_ticks; i++) begin
         step(k, 0, tag);
         step(k, 0, tag);
         step(k, 1, tag);
      end
   endtask

   int seen_sv;

   initial begin
      model_reset();
      enable = 1'b1;
      #12;
      check_outputs("reset");
      step(0, 1, "reset_hold");
      @(negedge clk);
      rst = 1'b1;
      step(0, 0, "idle");
      step(0, 1, "idle_tick");

      // dot: 2 ticks held
      step(1, 0, "dot_rise");
      hold(1, 2, "dot_hold");
      step(0, 0, "dot_fall");
      checks++;
      assert (mif.sym_valid === 1'b1 && mif.sym_dash === 1'b0) else begin
         errors++;
         $error("FAIL dot_sym got valid=%0b dash=%0b expected valid=1 dash=0", mif.sym_valid, mif.sym_dash);
      end
      hold(0, 8, "dot_gap");

      // dash then full letter and word gaps
      step(1, 0, "dash_rise");
      hold(1, 4, "dash_hold");
      step(0, 0, "dash_fall");
      hold(0, 8, "dash_gap");
      checks++;
      assert (mif.busy === 1'b0) else begin
         errors++;
         $error("FAIL word_busy got %0b expected 0", mif.busy);
      end

      // short gap: no letter_end, back into PRESS with a cleared count
      step(1, 0, "sg_rise");
      hold(1, 1, "sg_hold");
      step(0, 0, "sg_fall");
      hold(0, 2, "sg_gap");
      step(1, 0, "sg_repress");
      checks++;
      assert (dut.state === PRESS && dut.u_cnt.count === 4'd0) else begin
         errors++;
         $error("FAIL sg_state got state=%0d cnt=%0d expected state=%0d cnt=0",
                dut.state, dut.u_cnt.count, PRESS);
      end
      hold(1, 1, "sg_hold2");
      step(0, 0, "sg_fall2");
      hold(0, 8, "sg_tail");

      // tick coincident with fall at cnt=2 stays a dot
      step(1, 0, "sim_rise");
      hold(1, 2, "sim_hold");
      step(0, 1, "sim_fall_tick");
      checks++;
      assert (mif.sym_valid === 1'b1 && mif.sym_dash === 1'b0) else begin
         errors++;
         $error("FAIL sim_sym got valid=%0b dash=%0b expected valid=1 dash=0", mif.sym_valid, mif.sym_dash);
      end
      hold(0, 8, "sim_gap");

      // reset mid-press with key held through release of reset
      step(1, 0, "rst_rise");
      hold(1, 5, "rst_hold");
      @(negedge clk);
      #2 rst = 1'b0;
      model_reset();
      #1;
      check_outputs("rst_async");
      step(1, 1, "rst_in");
      step(1, 0, "rst_in");
      @(negedge clk);
      rst = 1'b1;
      seen_sv = 0;
      for (int i = 0; i < 12; i++) begin
         step(1, (i % 3) == 2, "rst_after");
         if (mif.sym_valid) seen_sv++;
      end
      checks++;
      assert (seen_sv == 0) else begin
         errors++;
         $error("FAIL rst_nosym got %0d sym_valid pulses expected 0", seen_sv);
      end
      step(0, 0, "rst_release_key");
      hold(0, 8, "rst_gap");

      // enable drop inside a gap, then re-enable with the key already held
      step(1, 0, "en_rise");
      hold(1, 1, "en_hold");
      step(0, 0, "en_fall");
      hold(0, 1, "en_gap");
      @(negedge clk);
      enable = 1'b0;
      hold(0, 9, "en_off");
      step(1, 0, "en_off_press");
      hold(1, 1, "en_off_hold");
      @(negedge clk);
      enable = 1'b1;
      hold(1, 2, "en_on_held");
      checks++;
      assert (mif.busy === 1'b0) else begin
         errors++;
         $error("FAIL en_held_busy got %0b expected 0", mif.busy);
      end
      step(0, 0, "en_release");
      step(1, 0, "en_repress");
      hold(1, 3, "en_repress_hold");
      step(0, 0, "en_repress_fall");
      hold(0, 8, "en_tail");

      // randomized soak
      for (int i = 0; i < 6000; i++) begin
         bit k, t;
         k = key;
         if ($urandom_range(0, 29) == 0) k = ~k;
         t = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 399) == 0) begin
            @(negedge clk);
            enable = ~enable;
         end
         if (!enable && $urandom_range(0, 19) == 0) begin
            @(negedge clk);
            enable = 1'b1;
         end
         if ($urandom_range(0, 1499) == 0) begin
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            step(k, t, "rand_rst");
            @(negedge clk);
            rst = 1'b1;
         end
         step(k, t, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/morse_key_timer.md
# morse_key_timer

Classifies the player's Morse key activity into dots, dashes, letter gaps and word gaps. It uses the shared 100 ms tick (`HundredmsTimeOut`) as its only timebase. It sits between the key input path, which is already synchronized and debounced, and the game-control FSM, and it emits one-cycle event pulses that game control consumes to build and check letters.

## Interface
Parameters:
- `DASH_TICKS`, default 3: a press lasting this many ticks or more is a dash; a shorter press is a dot.
- `LETTER_GAP_TICKS`, default 3: release duration, in ticks, that closes a letter.
- `WORD_GAP_TICKS`, default 7: release duration, in ticks, that closes a word. Must be greater than `LETTER_GAP_TICKS`.
- `CNT_W`, default 4: width of the duration counter. 2^`CNT_W`-1 must be at least `WORD_GAP_TICKS`.

Ports:
- `clk`, in, 1 bit: system clock.
- `rst`, in, 1 bit: asynchronous, active-low reset.
- `HundredmsTimeOut`, in, 1 bit: one-cycle tick every 100 ms.
- `enable`, in, 1 bit: high while a game round is accepting input.
- `key`, in, 1 bit: key pressed (1), already synchronized and debounced.
- `sym_valid`, out, 1 bit: one-cycle pulse marking that a symbol has completed.
- `sym_dash`, out, 1 bit: symbol type (1 = dash, 0 = dot), valid only while `sym_valid` is high.
- `letter_end`, out, 1 bit: one-cycle pulse when the letter gap elapses.
- `word_end`, out, 1 bit: one-cycle pulse when the word gap elapses.
- `busy`, out, 1 bit: high in the PRESS and GAP states.

## Operation
- `key_q` is a one-cycle registered copy of `key`.
  - Rise = `key & ~key_q`.
  - Fall = `~key & key_q`.
- `cnt` is a `CNT_W`-bit counter. It increments on `HundredmsTimeOut` and saturates at its all-ones value; it never wraps.
- The FSM has three states:
  - IDLE:
    - Rise → PRESS, `cnt` := 0.
  - PRESS:
    - Each tick increments `cnt`.
    - Fall → pulse `sym_valid`, with `sym_dash` = (`cnt` ≥ `DASH_TICKS`); then → GAP, `cnt` := 0.
  - GAP:
    - Each tick increments `cnt`.
    - When `cnt` first reaches `LETTER_GAP_TICKS`, pulse `letter_end` once.
    - When `cnt` reaches `WORD_GAP_TICKS`, pulse `word_end` and go → IDLE.
    - Rise → PRESS, `cnt` := 0. No `letter_end` is issued if the gap had not yet reached `LETTER_GAP_TICKS`.
- Simultaneous events:
  - A key edge and a tick in the same cycle: the edge wins, `cnt` := 0, and the tick is discarded.
  - In PRESS, the tick in the same cycle as Fall is also discarded. The classification uses the pre-edge `cnt`.
- A saturated press is still a dash. Press length has no upper limit.
- `enable` low:
  - Next state is IDLE and `cnt` := 0.
  - All pulses are suppressed, including a Fall that occurs in the same cycle.
  - `key_q` keeps tracking `key`, so a key already held when `enable` rises does not produce a Rise.
- Reset (`rst` = 0, asynchronous):
  - state = IDLE, `cnt` = 0, `key_q` = 0.
  - All outputs are 0.
  - Reset mid-press discards the pending symbol. No pulse is issued on exiting reset.

## Timing
- All outputs are registered.
- A Fall sampled at edge n produces `sym_valid`/`sym_dash` high for exactly cycle n+1.
- A tick sampled at edge n that makes `cnt` reach a threshold produces `letter_end`/`word_end` high in cycle n+1.
- `busy` follows the registered state: it is high the cycle after Rise and low the cycle after `word_end` is issued.
- `letter_end` and `word_end` are never high in the same cycle, because `WORD_GAP_TICKS` > `LETTER_GAP_TICKS`.
- No event pulse exceeds 1 cycle.
- At most one `sym_valid` is issued per press.
- Minimum resolvable press is 1 clock. A press with 0 ticks counted is a dot.

## Structure
- Package `morse_pkg`:
  - State enum `key_state_t` {IDLE, PRESS, GAP}.
  - Default constants for `DASH_TICKS`, `LETTER_GAP_TICKS` and `WORD_GAP_TICKS`, shared with the game-control and scoring blocks.
- Sub-module `morse_tick_cnt`:
  - Saturating `CNT_W`-bit counter.
  - Inputs: `clk`, `rst`, `clr`, `tick`. Output: `count`.
  - `clr` has priority over `tick`.
- The top level holds the edge detector, the FSM and the output registers.

## Test plan
- **Dot:** hold `key` for 2 ticks, release → one `sym_valid` with `sym_dash` = 0, one cycle after the release sample.
- **Dash, then gaps:** hold `key` for 4 ticks, release, leave released for 8 ticks → `sym_valid` with `sym_dash` = 1, then `letter_end` after the 3rd gap tick, `word_end` after the 7th, and `busy` low the following cycle.
- **Short gap:** dot, release 2 ticks, press again → no `letter_end`; state returns to PRESS with `cnt` = 0.
- **Simultaneous tick and Fall:** drive `HundredmsTimeOut` in the same cycle as the Fall, with `cnt` = 2 → `sym_dash` = 0 (dot, tick discarded).
- **Reset mid-press:** assert `rst` low at 5 ticks into a press, then release `rst` with `key` still high → all outputs 0, no `sym_valid`, and state IDLE until a fresh Rise.
- **Enable drop:** deassert `enable` during a 10-tick GAP → no `letter_end`/`word_end` and `busy` = 0. Reassert `enable` with `key` held → no Rise and no PRESS until the key is released and pressed again.
